comparator_out_responder: RTL and testbench
===========================================

Name: comparator_out_responder

Overview:
- Responder end of the comparator transaction path: accepts an operand pair (A, B) over a valid/ready input channel and performs a serial, MSB-first magnitude comparison.
- Returns a one-hot gt/eq/lt result over a valid/ready output channel.
- Used as the DUT-side endpoint and as the standalone bench responder for comparator in/out agents.
- One transaction in flight at a time.

Parameters:
- DATA_WIDTH, 8, operand width in bits (min 2).
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  DATA_WIDTH  operand A.
- in_b  input  DATA_WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_gt  output  1  A > B.
- out_eq  output  1  A == B.
- out_lt  output  1  A < B.
- busy  output  1  high in CMP or DONE state.

Behaviour:
- Reset (async assert, sync-safe release):
  - state=IDLE.
  - in_ready=1, out_valid=0, out_gt/out_eq/out_lt=0, busy=0.
  - Captured operands and bit index cleared.
- State IDLE:
  - in_ready=1.
  - in_valid&&in_ready at edge T: capture in_a/in_b, idx=DATA_WIDTH-1, clear the "decided" flag, go to CMP.
- State CMP:
  - in_ready=0.
  - Each cycle examines bit idx of the captured operands.
  - If the bits differ and no decision is recorded yet, record the result:
    - Unsigned: a[idx]=1 gives gt, else lt.
    - SIGNED=1 and idx==DATA_WIDTH-1: polarity inverted (a[MSB]=0 gives gt).
  - If idx==0 with no decision recorded: result=eq.
  - Transition to DONE at the next edge once decided (see Optional Feature), or when idx==0. Otherwise idx decrements.
- State DONE:
  - out_valid=1; exactly one of out_gt/out_eq/out_lt=1.
  - Outputs held stable while out_ready=0.
  - out_valid&&out_ready at an edge: go to IDLE, clear out_valid and the result flags.
  - No new operand is accepted in DONE.
- Latency (accept at edge T; bit i is the highest differing bit):
  - Early exit: out_valid high from cycle T+2+(DATA_WIDTH-1-i).
  - Equal operands: out_valid high from cycle T+1+DATA_WIDTH.
  - Minimum back-to-back period: latency + 1 cycle (the IDLE cycle).
- Boundaries:
  - in_valid held high during CMP/DONE is ignored; operands are not re-sampled.
  - Changing in_a/in_b after acceptance has no effect.
  - out_ready high outside DONE is ignored.
  - Reset asserted mid-CMP or mid-DONE: immediate return to IDLE, result discarded, out_valid drops asynchronously.
- Result flags are never all-zero while out_valid=1; never more than one is set.

Optional Feature:
- Macro: COMPARATOR_EARLY_EXIT_EN.
- Defined: CMP exits to DONE on the edge after the first differing bit. Latency is data-dependent, as above.
- Undefined: CMP always scans all bits down to idx 0 and keeps the first recorded difference. out_valid is always high from cycle T+1+DATA_WIDTH (constant latency). Results are identical in both builds.

Decomposition:
- Package comparator_resp_pkg:
  - State enum: IDLE, CMP, DONE.
  - Packed result typedef {gt, eq, lt}.
  - Constants RES_GT, RES_EQ, RES_LT, RES_NONE.
  - Function clog2-based index width.
- Sub-module comparator_bit_decide, combinational:
  - Inputs: a_bit, b_bit, is_msb, signed_mode.
  - Outputs: differ, a_greater.
  - Instantiated once in the CMP datapath.

Test Plan:
- DATA_WIDTH=8, SIGNED=0, early exit on; A=0x80, B=0x7F accepted at T -> out_valid at T+2, out_gt=1, busy low again after out_ready.
- SIGNED=1, A=0x80, B=0x7F -> out_lt=1 at T+2. A=0xFF, B=0xFE -> out_gt=1 at T+9 (bit 0 decides).
- A=B=0x5A -> out_eq=1 at T+9; repeat with the macro undefined -> identical result and timing. With the macro undefined, A=0x80, B=0x7F -> out_gt at T+9.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and flags stable, in_ready=0, a new in_valid pulse is ignored; out_ready=1 -> IDLE next cycle with in_ready=1.
- Assert reset at T+3 during the compare of A=0x01, B=0x02 -> out_valid and busy 0 immediately, in_ready=1 after release, next transaction A=0x03, B=0x03 returns out_eq.
- Back-to-back random stream of 1000 pairs with random out_ready stalls -> every result matches the reference model, exactly one flag set per result, no lost or duplicated transactions.

Source files
------------

// File: rtl/comparator_out_responder_pkg.sv
// Shared types for the comparator responder: FSM states, one-hot result encoding, index width helper.
// Optional early-exit behaviour is selected in the top by COMPARATOR_EARLY_EXIT_EN.
package comparator_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } result_t;

  localparam result_t RES_GT   = 3'b100;
  localparam result_t RES_EQ   = 3'b010;
  localparam result_t RES_LT   = 3'b001;
  localparam result_t RES_NONE = 3'b000;

  function automatic int idx_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/comparator_out_responder_if.sv
// Operand/result handshake bundle for the comparator responder; master drives operands and out_ready.
interface comparator_out_responder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_gt;
  logic                  out_eq;
  logic                  out_lt;
  logic                  busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_gt, out_eq, out_lt, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_gt, out_eq, out_lt, busy
  );
endinterface

// File: rtl/comparator_out_responder_bit_decide.sv
// Single-bit decision for the serial compare: flags a differing bit and which side wins it.
// Purely combinational; the MSB polarity flips in two's-complement mode.
module comparator_bit_decide (
  input  logic i_a_bit,
  input  logic i_b_bit,
  input  logic i_is_msb,
  input  logic i_signed_mode,
  output logic o_differ,
  output logic o_a_greater
);
  assign o_differ    = i_a_bit ^ i_b_bit;
  assign o_a_greater = (i_is_msb && i_signed_mode) ? ~i_a_bit : i_a_bit;
endmodule

// File: rtl/comparator_out_responder.sv
// Serial MSB-first magnitude comparator, one transaction in flight; result held in DONE until out_ready.
// COMPARATOR_EARLY_EXIT_EN: leave CMP on the first differing bit, else always scan every bit (fixed latency).
module comparator_out_responder
  import comparator_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SIGNED     = 0
) (
  input logic                       clock,
  input logic                       reset,
  comparator_out_responder_if.slave bus
);
  localparam int            IW          = idx_width(DATA_WIDTH);
  localparam logic [IW-1:0] MSB_IDX     = IW'(DATA_WIDTH - 1);
  localparam logic          SIGNED_MODE = (SIGNED != 0);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [IW-1:0]         r_idx;
  logic                  r_decided;
  result_t               r_res;
  result_t               w_res_out;

  logic w_differ;
  logic w_a_greater;
  logic w_last;
  logic w_record;
  logic w_cmp_exit;

  comparator_bit_decide u_bit_decide (
    .i_a_bit       (r_a[r_idx]),
    .i_b_bit       (r_b[r_idx]),
    .i_is_msb      (r_idx == MSB_IDX),
    .i_signed_mode (SIGNED_MODE),
    .o_differ      (w_differ),
    .o_a_greater   (w_a_greater)
  );

  assign w_last   = (r_idx == '0);
  assign w_record = (r_state == CMP) && w_differ && !r_decided;

`ifdef COMPARATOR_EARLY_EXIT_EN
  assign w_cmp_exit = w_differ || w_last;
`else
  assign w_cmp_exit = w_last;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_state_nxt = CMP;
      CMP:     if (w_cmp_exit)    w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // First recorded difference wins; later bits are only scanned in the fixed-latency build.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_decided <= 1'b0;
      r_res     <= RES_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a       <= bus.in_a;
            r_b       <= bus.in_b;
            r_idx     <= MSB_IDX;
            r_decided <= 1'b0;
            r_res     <= RES_NONE;
          end
        end
        CMP: begin
          if (w_record) begin
            r_res     <= w_a_greater ? RES_GT : RES_LT;
            r_decided <= 1'b1;
          end else if (w_last && !r_decided) begin
            r_res <= RES_EQ;
          end
          if (!w_last) begin
            r_idx <= r_idx - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_res <= RES_NONE;
          end
        end
        default: r_res <= RES_NONE;
      endcase
    end
  end

  assign w_res_out     = (r_state == DONE) ? r_res : RES_NONE;
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_gt    = w_res_out.gt;
  assign bus.out_eq    = w_res_out.eq;
  assign bus.out_lt    = w_res_out.lt;

endmodule

// File: tb/tb_comparator_out_responder.sv
// Bench for comparator_out_responder: unsigned and signed instances driven in lockstep and checked
// each cycle against an arithmetic reference model, plus literal directed expectations.
module tb_comparator_out_responder;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_acc = 0;
  bit chk_en = 1'b0;

  comparator_out_responder_if #(.DATA_WIDTH(W)) u_if ();
  comparator_out_responder_if #(.DATA_WIDTH(W)) s_if ();

  assign u_if.in_valid  = in_valid;
  assign u_if.in_a      = in_a;
  assign u_if.in_b      = in_b;
  assign u_if.out_ready = out_ready;
  assign s_if.in_valid  = in_valid;
  assign s_if.in_a      = in_a;
  assign s_if.in_b      = in_b;
  assign s_if.out_ready = out_ready;

  comparator_out_responder #(.DATA_WIDTH(W), .SIGNED(0)) dut_u (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.slave)
  );

  comparator_out_responder #(.DATA_WIDTH(W), .SIGNED(1)) dut_s (
    .clock (clock),
    .reset (reset),
    .bus   (s_if.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic [2:0] dut_res [2];
  logic [2:0] dut_ctl [2];
  assign dut_res[0] = {u_if.out_gt, u_if.out_eq, u_if.out_lt};
  assign dut_res[1] = {s_if.out_gt, s_if.out_eq, s_if.out_lt};
  assign dut_ctl[0] = {u_if.in_ready, u_if.busy, u_if.out_valid};
  assign dut_ctl[1] = {s_if.in_ready, s_if.busy, s_if.out_valid};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: {gt,eq,lt} from plain arithmetic compare.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    if (sgn) begin
      if ($signed(a) > $signed(b)) return 3'b100;
      if ($signed(a) < $signed(b)) return 3'b001;
      return 3'b010;
    end
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    return 3'b010;
  endfunction

  // Edges from the accept edge until the result is visible.
  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef COMPARATOR_EARLY_EXIT_EN
    logic [W-1:0] x;
    x = a ^ b;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i]) return W - i;
    end
    return W;
`else
    return W + 0 * int'(a ^ b);
`endif
  endfunction

  // Model phases: 0 waiting for operands, 1 computing, 2 result presented.
  int         m_phase [2] = '{0, 0};
  int         m_cnt   [2] = '{0, 0};
  logic [2:0] m_res   [2] = '{3'b000, 3'b000};

  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_phase[k] <= 0;
        m_cnt[k]   <= 0;
        m_res[k]   <= 3'b000;
      end else if (m_phase[k] == 0) begin
        if (in_valid) begin
          m_phase[k] <= 1;
          m_cnt[k]   <= ref_lat(in_a, in_b);
          m_res[k]   <= ref_cmp(in_a, in_b, k == 1);
        end
      end else if (m_phase[k] == 1) begin
        m_cnt[k] <= m_cnt[k] - 1;
        if (m_cnt[k] == 1) m_phase[k] <= 2;
      end else if (out_ready) begin
        m_phase[k] <= 0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk(k == 0 ? "u_ctl" : "s_ctl", dut_ctl[k],
            {m_phase[k] == 0, m_phase[k] != 0, m_phase[k] == 2});
        chk(k == 0 ? "u_res" : "s_res", dut_res[k], (m_phase[k] == 2) ? m_res[k] : 3'b000);
        if (dut_ctl[k][0]) chk(k == 0 ? "u_onehot" : "s_onehot", $countones(dut_res[k]), 1);
      end
    end
  end

  // Transaction scoreboard: every accepted pair yields exactly one delivered result.
  logic [5:0] sb_q [$];
  int n_acc = 0;
  int n_done = 0;
  int n_disc = 0;

  always @(posedge reset) begin
    n_disc += sb_q.size();
    sb_q.delete();
  end

  always @(posedge clock) begin
    if (!reset && chk_en) begin
      if (m_phase[0] == 0 && in_valid) begin
        sb_q.push_back({ref_cmp(in_a, in_b, 0), ref_cmp(in_a, in_b, 1)});
        n_acc++;
      end
      if (u_if.out_valid && out_ready) begin
        n_done++;
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_result", 1, 0);
        end else begin
          chk("sb_result", {dut_res[0], dut_res[1]}, sb_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    @(negedge clock);
    while (!u_if.in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!u_if.in_ready) chk("send_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    t_acc    = cyc;
    @(negedge clock);
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = W'($urandom);
  endtask

  task automatic run_dir(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] eu, input logic [2:0] es, input int lat_early);
    int n;
    int lat_exp;
`ifdef COMPARATOR_EARLY_EXIT_EN
    lat_exp = lat_early;
`else
    lat_exp = W + 0 * lat_early;
`endif
    send(a, b);
    n = 0;
    while (!u_if.out_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_valid"}, u_if.out_valid, 1);
    chk({nm, "_lat"}, cyc - t_acc - 1, lat_exp);
    chk({nm, "_u"}, dut_res[0], eu);
    chk({nm, "_s"}, dut_res[1], es);
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    int target;
    logic [W-1:0] ra, rb, one;

    #1 reset = 1'b1;
    @(negedge clock);
    chk_en = 1'b1;
    chk("rst_in_ready", u_if.in_ready, 1);
    chk("rst_out_valid", u_if.out_valid, 0);
    chk("rst_busy", s_if.busy, 0);
    chk("rst_flags", {dut_res[0], dut_res[1]}, 0);
    @(negedge clock);
    reset = 1'b0;

    run_dir("msb_80_7f", 8'h80, 8'h7F, 3'b100, 3'b001, 1);
    chk("idle_after_msb", u_if.busy, 0);
    run_dir("msb_7f_80", 8'h7F, 8'h80, 3'b001, 3'b100, 1);
    run_dir("lsb_ff_fe", 8'hFF, 8'hFE, 3'b100, 3'b100, 8);
    run_dir("eq_5a", 8'h5A, 8'h5A, 3'b010, 3'b010, 8);
    run_dir("mid_10_20", 8'h10, 8'h20, 3'b001, 3'b001, 3);

    // Backpressure: result must hold while out_ready is low, new operands ignored.
    out_ready = 1'b0;
    send(8'h5A, 8'h3C);
    guard = 0;
    while (!u_if.out_valid && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", u_if.out_valid, 1);
      chk("bp_flags", {dut_res[0], dut_res[1]}, 6'b100100);
      chk("bp_in_ready", u_if.in_ready, 0);
      in_valid = (i == 2);
      in_a     = 8'h00;
      in_b     = 8'hFF;
      @(negedge clock);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_in_ready", u_if.in_ready, 1);
    chk("bp_release_valid", u_if.out_valid, 0);

    // Reset in the middle of a compare.
    send(8'h01, 8'h02);
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", u_if.busy, 0);
    chk("midrst_valid", s_if.out_valid, 0);
    chk("midrst_in_ready", u_if.in_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_in_ready", u_if.in_ready, 1);
    run_dir("eq_03", 8'h03, 8'h03, 3'b010, 3'b010, 8);

    // Random back-to-back stream with consumer stalls.
    target = n_done + 1000;
    one    = 8'h01;
    fork
      begin
        for (int t = 0; t < 1000; t++) begin
          ra = W'($urandom);
          case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ (one << $urandom_range(0, W - 1));
            default: rb = W'($urandom);
          endcase
          send(ra, rb);
        end
      end
      begin
        guard = 0;
        while (n_done < target && guard < 40000) begin
          @(negedge clock);
          out_ready = ($urandom_range(0, 3) != 0);
          guard++;
        end
        chk("stream_complete", n_done, target);
      end
    join
    out_ready = 1'b1;
    repeat (3) @(negedge clock);

    chk("sb_empty", sb_q.size(), 0);
    chk("sb_count", n_done, n_acc - n_disc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
